krnl_vmul_hls_deadlock_report_unit: RTL

KRNL_VMUL_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: krnl_vmul_hls_deadlock_report_unit

---
 rtl/krnl_vmul_hls_deadlock_report_unit_if.sv | 25 ++
 rtl/krnl_vmul_hls_deadlock_report_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/krnl_vmul_hls_deadlock_report_unit_if.sv
// Report channel of the deadlock report unit: valid/ready handshake
// carrying the origin index and the set of processes the token visited.
interface krnl_vmul_hls_deadlock_report_unit_if #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2
);
  logic                report_valid;
  logic                report_ready;
  logic [ID_W-1:0]     report_origin;
  logic [PROC_NUM-1:0] report_cycle_vec;

  modport master (
    output report_valid,
    output report_origin,
    output report_cycle_vec,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_origin,
    input  report_cycle_vec,
    output report_ready
  );
endinterface

// File: rtl/krnl_vmul_hls_deadlock_report_unit.sv
// Confirms a dataflow deadlock by walking a token around the wait-for ring
// from the lowest-index detecting process, then reports the visited cycle.
module krnl_vmul_hls_deadlock_report_unit #(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_detect_out,
  output logic [7:0]          abort_cnt,
  krnl_vmul_hls_deadlock_report_unit_if.master rpt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ORIGIN, S_WALK, S_CLEAR, S_ABORT, S_REPORT, S_DONE
  } state_t;

  localparam logic [PROC_NUM-1:0] ONE       = {{(PROC_NUM-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]     WALK_LAST = ID_W'(PROC_NUM - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     origin_id_q, origin_id_d;
  logic [ID_W-1:0]     walk_cnt_q, walk_cnt_d;
  logic [PROC_NUM-1:0] cycle_vec_q, cycle_vec_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic                token_clear_q, token_clear_d;
  logic                dl_detect_q, dl_detect_d;
  logic                report_valid_q, report_valid_d;
  logic [ID_W-1:0]     report_origin_q, report_origin_d;
  logic [PROC_NUM-1:0] report_cycle_vec_q, report_cycle_vec_d;
  logic [7:0]          abort_cnt_q, abort_cnt_d;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d            = state_q;
    origin_id_d        = origin_id_q;
    walk_cnt_d         = walk_cnt_q;
    cycle_vec_d        = cycle_vec_q;
    report_origin_d    = report_origin_q;
    report_cycle_vec_d = report_cycle_vec_q;
    abort_cnt_d        = abort_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|dl_in_vec) begin
          origin_id_d = lowest_idx(dl_in_vec);
          state_d     = S_ORIGIN;
        end
      end
      S_ORIGIN: begin
        cycle_vec_d = ONE << origin_id_q;
        walk_cnt_d  = '0;
        state_d     = S_WALK;
      end
      S_WALK: begin
        cycle_vec_d = cycle_vec_q | token_vec;
        walk_cnt_d  = walk_cnt_q + 1'b1;
        // Return to origin wins over lost-token and timeout on the same cycle.
        if (token_vec[origin_id_q]) begin
          state_d = S_CLEAR;
        end else if (token_vec == '0 || walk_cnt_q == WALK_LAST) begin
          state_d     = S_ABORT;
          abort_cnt_d = sat_inc8(abort_cnt_q);
        end
      end
      S_CLEAR: begin
        report_origin_d    = origin_id_q;
        report_cycle_vec_d = cycle_vec_q;
        state_d            = S_REPORT;
      end
      S_ABORT:  state_d = S_IDLE;
      S_REPORT: if (rpt.report_ready) state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase

    // Moore outputs are decoded from the next state so they register with it.
    origin_d       = (state_d == S_ORIGIN) ? (ONE << origin_id_d) : '0;
    token_clear_d  = (state_d == S_CLEAR) || (state_d == S_ABORT);
    dl_detect_d    = dl_detect_q || (state_d == S_CLEAR);
    report_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      origin_id_q        <= '0;
      walk_cnt_q         <= '0;
      cycle_vec_q        <= '0;
      origin_q           <= '0;
      token_clear_q      <= 1'b0;
      dl_detect_q        <= 1'b0;
      report_valid_q     <= 1'b0;
      report_origin_q    <= '0;
      report_cycle_vec_q <= '0;
      abort_cnt_q        <= '0;
    end else begin
      state_q            <= state_d;
      origin_id_q        <= origin_id_d;
      walk_cnt_q         <= walk_cnt_d;
      cycle_vec_q        <= cycle_vec_d;
      origin_q           <= origin_d;
      token_clear_q      <= token_clear_d;
      dl_detect_q        <= dl_detect_d;
      report_valid_q     <= report_valid_d;
      report_origin_q    <= report_origin_d;
      report_cycle_vec_q <= report_cycle_vec_d;
      abort_cnt_q        <= abort_cnt_d;
    end
  end

  assign origin               = origin_q;
  assign token_clear          = token_clear_q;
  assign dl_detect_out        = dl_detect_q;
  assign abort_cnt            = abort_cnt_q;
  assign rpt.report_valid     = report_valid_q;
  assign rpt.report_origin    = report_origin_q;
  assign rpt.report_cycle_vec = report_cycle_vec_q;

endmodule
